mac_cluster_cfg_loader: RTL and testbench
=========================================

Name: mac_cluster_cfg_loader

Overview:
- Configuration sequencer for one baked MAC cluster (4 MACs, MAC_CONF_WIDTH bits each).
- Accepts configuration words over a valid/ready stream and serializes them LSB-first into the cluster scan chain on mac_shift_in with mac_cen asserted.
- Pulses mac_cset once the whole chain is loaded, then enables computation on request.
- Sits between the fabric config bus and the cluster's cen/cset/shift_in/en pins.

Parameters:
- NUM_MACS, 4, MACs in the cluster
- MAC_CONF_WIDTH, 4, config bits per MAC
- CHAIN_LEN, NUM_MACS*MAC_CONF_WIDTH, total scan-chain bits (derived; do not override)
- WORD_WIDTH, 8, config word width
- N_WORDS, ceil(CHAIN_LEN/WORD_WIDTH), words per load (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- cfg_start  in  1  begin a load (sampled in IDLE only)
- cfg_abort  in  1  cancel an in-progress load
- cfg_word  in  WORD_WIDTH  config data
- cfg_word_valid  in  1  cfg_word valid
- cfg_word_ready  out  1  loader accepts word
- run_en  in  1  user request to run MACs
- busy  out  1  load in progress (state != IDLE)
- done  out  1  one-cycle pulse on load completion
- configured  out  1  chain holds a complete, committed config
- mac_cen  out  1  scan-chain shift enable
- mac_shift_in  out  1  scan-chain serial data
- mac_cset  out  1  commit pulse to cluster
- mac_en  out  1  MAC enable
- mac_shift_out  in  1  chain serial output (readback only)
- rb_data  out  CHAIN_LEN  readback of previous chain contents

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; all outputs 0; counters and shift register cleared; configured=0.
- Outputs are Moore-decoded from registered state and datapath regs; no combinational input-to-output paths except cfg_word_ready (state only).
- States: IDLE, WAIT_WORD, SHIFT, SET, DONE.
- IDLE:
  - cfg_start=1 -> WAIT_WORD.
  - configured cleared and word/bit counters zeroed on the same edge.
- WAIT_WORD:
  - cfg_word_ready=1, mac_cen=0.
  - On valid&ready, capture the word into a shift reg -> SHIFT.
  - Without valid, stall indefinitely; the chain does not shift.
- SHIFT:
  - mac_cen=1, mac_shift_in = shift_reg[0]; shift right one bit per cycle.
  - Bits emitted for this word: WORD_WIDTH, except the last word, which emits CHAIN_LEN - (N_WORDS-1)*WORD_WIDTH; its unused upper bits are ignored.
  - After the word's last bit: -> WAIT_WORD if more words remain, else -> SET.
- SET: mac_cset=1, mac_cen=0 for exactly one cycle -> DONE.
- DONE: done=1 for one cycle, configured set to 1 -> IDLE.
- Latency: with cfg_start sampled at cycle 0 and valid always high, done=1 at cycle N_WORDS+CHAIN_LEN+2.
- mac_en = run_en & configured & ~busy, registered (1-cycle latency from run_en).
- cfg_abort=1 in any non-IDLE state:
  - -> IDLE next edge; mac_cset is never pulsed; configured stays 0; done not asserted.
  - Abort has priority over the handshake and state advance in the same cycle.
- cfg_start while busy: ignored. cfg_start and cfg_abort together in IDLE: abort ignored, load starts.
- mac_cen and mac_cset are never high in the same cycle.
- Reset mid-load: identical to the power-on reset values.

Optional Feature:
- MAC_CFG_READBACK_EN defined:
  - Each cycle mac_cen=1, mac_shift_out is shifted MSB-first into a CHAIN_LEN register.
  - On DONE the register is copied to rb_data, which holds until the next DONE or reset.
  - After a full load, rb_data equals the prior chain contents, with the bit first emitted by the chain in rb_data[0].
- Undefined: rb_data tied to 0, no capture register; mac_shift_out unused.

Decomposition:
- Shared package mac_cfg_pkg:
  - state enum (IDLE, WAIT_WORD, SHIFT, SET, DONE);
  - constants NUM_MACS, MAC_CONF_WIDTH, CHAIN_LEN, N_WORDS;
  - $clog2-derived widths for the bit and word counters.
- One natural sub-module, mac_cfg_serializer: word capture, shift register, bit counter with last-word partial length, driving mac_shift_in and a bit_last flag. The FSM stays in the top.

Test Plan:
- Defaults: start, words 0xA5 then 0x3C, valid always high -> mac_shift_in during cen cycles = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; cset high at cycle 19 only; done at cycle 20; configured=1 from cycle 21.
- CHAIN_LEN=12 (NUM_MACS=3): words 0xFF, 0x0F -> exactly 12 cen cycles (8+4), all bits 1; upper nibble of the second word never shifted.
- Hold valid low 5 cycles before the second word -> cen low during the stall; done delayed by exactly 5 cycles; bit stream unchanged.
- cfg_abort during the 3rd SHIFT cycle of word 1 -> IDLE next cycle; no cset, no done, configured=0; a following full load succeeds normally.
- run_en=1 throughout; load a second config -> mac_en falls when busy rises, returns 1 cycle after configured=1.
- With MAC_CFG_READBACK_EN: load 0xA5,0x3C twice -> after the second done, rb_data=16'h3CA5; without the macro, rb_data=0.

Source files
------------

// File: rtl/mac_cluster_cfg_loader_pkg.sv
// Shared types and default geometry for the MAC cluster configuration loader.
// Counter-width helper is used by the serializer to size its bit/word counters.
package mac_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_WORD = 3'd1,
    SHIFT     = 3'd2,
    SET       = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int NUM_MACS       = 4;
  localparam int MAC_CONF_WIDTH = 4;
  localparam int WORD_WIDTH     = 8;
  localparam int CHAIN_LEN      = NUM_MACS * MAC_CONF_WIDTH;
  localparam int N_WORDS        = (CHAIN_LEN + WORD_WIDTH - 1) / WORD_WIDTH;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BIT_CNT_W  = cnt_width(WORD_WIDTH);
  localparam int WORD_CNT_W = cnt_width(N_WORDS);

endpackage

// File: rtl/mac_cluster_cfg_loader_if.sv
// Fabric-side configuration stream: start/abort control plus valid/ready word handshake.
interface mac_cluster_cfg_loader_if #(
  parameter int WORD_WIDTH = mac_cfg_pkg::WORD_WIDTH
);
  logic                  cfg_start;
  logic                  cfg_abort;
  logic [WORD_WIDTH-1:0] cfg_word;
  logic                  cfg_word_valid;
  logic                  cfg_word_ready;

  modport master (
    output cfg_start, cfg_abort, cfg_word, cfg_word_valid,
    input  cfg_word_ready
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_word, cfg_word_valid,
    output cfg_word_ready
  );
endinterface

// File: rtl/mac_cluster_cfg_loader_serializer.sv
// Word capture and LSB-first serialization; the final word of a load emits only
// the bits that still fit in the scan chain.
module mac_cfg_serializer #(
  parameter int WORD_WIDTH = 8,
  parameter int CHAIN_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] word,
  output logic                  shift_bit,
  output logic                  bit_last,
  output logic                  word_last
);
  import mac_cfg_pkg::*;

  localparam int NW        = (CHAIN_LEN + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int LAST_BITS = CHAIN_LEN - (NW - 1) * WORD_WIDTH;
  localparam int BIT_W     = cnt_width(WORD_WIDTH);
  localparam int WORD_W    = cnt_width(NW);

  localparam logic [BIT_W-1:0]  FULL_LAST = BIT_W'(WORD_WIDTH - 1);
  localparam logic [BIT_W-1:0]  PART_LAST = BIT_W'(LAST_BITS - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NW - 1);

  logic [WORD_WIDTH-1:0] shreg_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic [WORD_W-1:0]     word_cnt_r;

  assign shift_bit = shreg_r[0];
  assign word_last = (word_cnt_r == LAST_WORD);
  assign bit_last  = shift && (bit_cnt_r == (word_last ? PART_LAST : FULL_LAST));

  // Shift register and bit/word counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_r    <= {WORD_WIDTH{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
      word_cnt_r <= {WORD_W{1'b0}};
    end else if (clear) begin
      shreg_r    <= {WORD_WIDTH{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
      word_cnt_r <= {WORD_W{1'b0}};
    end else if (load) begin
      shreg_r   <= word;
      bit_cnt_r <= {BIT_W{1'b0}};
    end else if (shift) begin
      shreg_r <= {1'b0, shreg_r[WORD_WIDTH-1:1]};
      if (bit_last) begin
        bit_cnt_r  <= {BIT_W{1'b0}};
        word_cnt_r <= word_cnt_r + 1'b1;
      end else begin
        bit_cnt_r <= bit_cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_cluster_cfg_loader.sv
// Scan-chain configuration sequencer for one MAC cluster.
// Optional MAC_CFG_READBACK_EN captures the previous chain contents into rb_data.
module mac_cluster_cfg_loader #(
  parameter int NUM_MACS       = mac_cfg_pkg::NUM_MACS,
  parameter int MAC_CONF_WIDTH = mac_cfg_pkg::MAC_CONF_WIDTH,
  parameter int WORD_WIDTH     = mac_cfg_pkg::WORD_WIDTH,
  localparam int CHAIN_LEN     = NUM_MACS * MAC_CONF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  mac_cluster_cfg_loader_if.slave  cfg,
  input  logic                     run_en,
  output logic                     busy,
  output logic                     done,
  output logic                     configured,
  output logic                     mac_cen,
  output logic                     mac_shift_in,
  output logic                     mac_cset,
  output logic                     mac_en,
  input  logic                     mac_shift_out,
  output logic [CHAIN_LEN-1:0]     rb_data
);
  import mac_cfg_pkg::*;

  state_t state_r;
  logic   configured_r;
  logic   mac_en_r;
  logic   start_s;
  logic   abort_s;
  logic   load_s;
  logic   shift_s;
  logic   shift_bit_s;
  logic   bit_last_s;
  logic   word_last_s;

  assign start_s = (state_r == IDLE) && cfg.cfg_start;
  assign abort_s = (state_r != IDLE) && cfg.cfg_abort;
  assign load_s  = (state_r == WAIT_WORD) && cfg.cfg_word_valid && !abort_s;
  assign shift_s = (state_r == SHIFT) && !abort_s;

  mac_cfg_serializer #(
    .WORD_WIDTH (WORD_WIDTH),
    .CHAIN_LEN  (CHAIN_LEN)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_s),
    .load      (load_s),
    .shift     (shift_s),
    .word      (cfg.cfg_word),
    .shift_bit (shift_bit_s),
    .bit_last  (bit_last_s),
    .word_last (word_last_s)
  );

  // Load sequencing FSM, committed-config flag and MAC enable
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      configured_r <= 1'b0;
      mac_en_r     <= 1'b0;
    end else begin
      // A new load drops the enable together with busy rising
      mac_en_r <= start_s ? 1'b0 : (run_en && configured_r && (state_r == IDLE));
      if (abort_s) begin
        state_r <= IDLE;
      end else begin
        case (state_r)
          IDLE: begin
            if (cfg.cfg_start) begin
              state_r      <= WAIT_WORD;
              configured_r <= 1'b0;
            end
          end
          WAIT_WORD: begin
            if (cfg.cfg_word_valid) state_r <= SHIFT;
          end
          SHIFT: begin
            if (bit_last_s) state_r <= word_last_s ? SET : WAIT_WORD;
          end
          SET:     state_r <= DONE;
          DONE: begin
            state_r      <= IDLE;
            configured_r <= 1'b1;
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign busy               = (state_r != IDLE);
  assign cfg.cfg_word_ready = (state_r == WAIT_WORD);
  assign mac_cen            = (state_r == SHIFT);
  assign mac_shift_in       = (state_r == SHIFT) && shift_bit_s;
  assign mac_cset           = (state_r == SET);
  assign done               = (state_r == DONE);
  assign configured         = configured_r;
  assign mac_en             = mac_en_r;

`ifdef MAC_CFG_READBACK_EN
  logic [CHAIN_LEN-1:0] cap_r;
  logic [CHAIN_LEN-1:0] rb_r;

  // Capture the old chain as it drains, publish it when the load completes
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_r <= {CHAIN_LEN{1'b0}};
      rb_r  <= {CHAIN_LEN{1'b0}};
    end else begin
      if (state_r == SHIFT) cap_r <= {mac_shift_out, cap_r[CHAIN_LEN-1:1]};
      if (state_r == DONE)  rb_r  <= cap_r;
    end
  end

  assign rb_data = rb_r;
`else
  logic unused_shift_out_s;
  assign unused_shift_out_s = mac_shift_out;
  assign rb_data = {CHAIN_LEN{1'b0}};
`endif

endmodule

// File: tb/tb_mac_cluster_cfg_loader.sv
// Directed bench: default 16-bit chain plus a 12-bit chain instance, with
// behavioural scan-chain stubs feeding mac_shift_out.
module tb_mac_cluster_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, valid, run_en, sel;
  logic [7:0] cfg_w;

  mac_cluster_cfg_loader_if #(.WORD_WIDTH(8)) ifa ();
  mac_cluster_cfg_loader_if #(.WORD_WIDTH(8)) ifb ();

  assign ifa.cfg_start      = start;
  assign ifa.cfg_abort      = abort;
  assign ifa.cfg_word       = cfg_w;
  assign ifa.cfg_word_valid = valid;
  assign ifb.cfg_start      = start;
  assign ifb.cfg_abort      = abort;
  assign ifb.cfg_word       = cfg_w;
  assign ifb.cfg_word_valid = valid;

  logic        busy_a, done_a, cfgd_a, cen_a, sin_a, cset_a, en_a;
  logic        busy_b, done_b, cfgd_b, cen_b, sin_b, cset_b, en_b;
  logic [15:0] rb_a, chain_a;
  logic [11:0] rb_b, chain_b;

  mac_cluster_cfg_loader u_dut (
    .clk(clk), .rst(rst), .cfg(ifa.slave), .run_en(run_en),
    .busy(busy_a), .done(done_a), .configured(cfgd_a), .mac_cen(cen_a),
    .mac_shift_in(sin_a), .mac_cset(cset_a), .mac_en(en_a),
    .mac_shift_out(chain_a[0]), .rb_data(rb_a)
  );

  mac_cluster_cfg_loader #(.NUM_MACS(3)) u_dut12 (
    .clk(clk), .rst(rst), .cfg(ifb.slave), .run_en(run_en),
    .busy(busy_b), .done(done_b), .configured(cfgd_b), .mac_cen(cen_b),
    .mac_shift_in(sin_b), .mac_cset(cset_b), .mac_en(en_b),
    .mac_shift_out(chain_b[0]), .rb_data(rb_b)
  );

  initial begin
    chain_a = 16'h0000;
    chain_b = 12'h000;
  end

  always @(posedge clk) begin
    if (cen_a) chain_a <= {sin_a, chain_a[15:1]};
    if (cen_b) chain_b <= {sin_b, chain_b[11:1]};
  end

  logic s_ready, s_busy, s_done, s_cfgd, s_cen, s_sin, s_cset, s_en;
  assign s_ready = sel ? ifb.cfg_word_ready : ifa.cfg_word_ready;
  assign s_busy  = sel ? busy_b : busy_a;
  assign s_done  = sel ? done_b : done_a;
  assign s_cfgd  = sel ? cfgd_b : cfgd_a;
  assign s_cen   = sel ? cen_b  : cen_a;
  assign s_sin   = sel ? sin_b  : sin_a;
  assign s_cset  = sel ? cset_b : cset_a;
  assign s_en    = sel ? en_b   : en_a;

  int checks_n = 0;
  int errors_n = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_n++;
    if (act !== exp) begin
      errors_n++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [31:0] bits;
  int          nbits, cset_c, cset_n, done_c, done_n, cfgd_c, overlap;
  logic        busy_log [0:31];
  logic        en_log   [0:31];

  // One load of up to two words; records what the selected DUT does per cycle.
  task automatic do_load(input logic [7:0] w0, input logic [7:0] w1,
                         input int stall, input int abort_c);
    int   sent, stall_n;
    logic acc;
    bits = 32'h0; nbits = 0; cset_c = -1; cset_n = 0; done_c = -1; done_n = 0;
    cfgd_c = -1; overlap = 0; sent = 0; stall_n = 0; acc = 1'b0;
    en_log[0] = s_en; busy_log[0] = s_busy;
    start = 1'b1; cfg_w = w0; valid = 1'b1;
    for (int c = 1; c < 32; c++) begin
      @(posedge clk); #1;
      if (acc) begin sent++; cfg_w = w1; end
      start = 1'b0;
      abort = (c == abort_c);
      busy_log[c] = s_busy;
      en_log[c]   = s_en;
      if (s_cen && nbits < 32) begin bits[nbits] = s_sin; nbits++; end
      if (s_cset) begin cset_n++; if (cset_c < 0) cset_c = c; end
      if (s_done) begin done_n++; if (done_c < 0) done_c = c; end
      if (s_cen && s_cset) overlap++;
      if (s_cfgd && cfgd_c < 0) cfgd_c = c;
      if (s_ready && sent == 1 && stall_n < stall) begin
        valid = 1'b0; stall_n++;
      end else begin
        valid = 1'b1;
      end
      acc = s_ready && valid;
    end
    abort = 1'b0; valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0; run_en = 1'b0;
    sel = 1'b0; cfg_w = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {24'h0, s_ready, s_busy, s_done, s_cfgd, s_cen, s_sin, s_cset, s_en}, 32'h0);
    check_eq("reset_rb", {16'h0, rb_a}, 32'h0);
    rst = 1'b1; run_en = 1'b1;
    @(posedge clk); #1;

    do_load(8'hA5, 8'h3C, 0, 0);
    check_eq("l1_bits", bits, 32'h0000_3CA5);
    check_eq("l1_nbits", nbits, 16);
    check_eq("l1_cset_cyc", cset_c, 19);
    check_eq("l1_cset_cnt", cset_n, 1);
    check_eq("l1_done_cyc", done_c, 20);
    check_eq("l1_done_cnt", done_n, 1);
    check_eq("l1_cfgd_cyc", cfgd_c, 21);
    check_eq("l1_overlap", overlap, 0);
    check_eq("l1_en_c21", {31'h0, en_log[21]}, 32'h0);
    check_eq("l1_en_c22", {31'h0, en_log[22]}, 32'h1);

    do_load(8'hA5, 8'h3C, 0, 0);
    check_eq("l2_en_before", {31'h0, en_log[0]}, 32'h1);
    check_eq("l2_busy_c1", {31'h0, busy_log[1]}, 32'h1);
    check_eq("l2_en_c1", {31'h0, en_log[1]}, 32'h0);
    check_eq("l2_en_c22", {31'h0, en_log[22]}, 32'h1);
`ifdef MAC_CFG_READBACK_EN
    check_eq("l2_rb", {16'h0, rb_a}, 32'h0000_3CA5);
`else
    check_eq("l2_rb", {16'h0, rb_a}, 32'h0);
`endif

    do_load(8'hA5, 8'h3C, 5, 0);
    check_eq("stall_bits", bits, 32'h0000_3CA5);
    check_eq("stall_cset_cyc", cset_c, 24);
    check_eq("stall_done_cyc", done_c, 25);

    do_load(8'hA5, 8'h3C, 0, 4);
    check_eq("abort_nbits", nbits, 3);
    check_eq("abort_bits", bits, 32'h5);
    check_eq("abort_busy_c5", {31'h0, busy_log[5]}, 32'h0);
    check_eq("abort_cset_cnt", cset_n, 0);
    check_eq("abort_done_cnt", done_n, 0);
    check_eq("abort_cfgd_cyc", cfgd_c, -1);

    do_load(8'hA5, 8'h3C, 0, 0);
    check_eq("post_abort_bits", bits, 32'h0000_3CA5);
    check_eq("post_abort_done", done_c, 20);

    sel = 1'b1;
    do_load(8'hFF, 8'h0F, 0, 0);
    check_eq("c12_nbits", nbits, 12);
    check_eq("c12_bits", bits, 32'h0000_0FFF);
    check_eq("c12_cset_cyc", cset_c, 15);
    check_eq("c12_done_cyc", done_c, 16);
    check_eq("c12_cfgd_cyc", cfgd_c, 17);
    sel = 1'b0;

    start = 1'b1; cfg_w = 8'h5A; valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("midload_busy", {31'h0, s_busy}, 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("midload_reset", {24'h0, s_ready, s_busy, s_done, s_cfgd, s_cen, s_sin, s_cset, s_en}, 32'h0);
    check_eq("midload_rb", {16'h0, rb_a}, 32'h0);
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
